// File: rtl/sensor_scan_sched.sv
// Sensor-group scan sequencer: enables each masked sensor in turn, waits out its settle
// time, samples it, then offers the collected result vector to the host with a sticky alarm.
module sensor_scan_sched #(
  parameter int NUM_SENSORS   = 10,
  parameter int IDX_W         = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_SENSORS-1:0] cfg_mask,
  input  logic                   clear_alarm,
  input  logic [NUM_SENSORS-1:0] sensor_in,
  output logic [NUM_SENSORS-1:0] sensor_en,
  output logic                   busy,
  output logic [IDX_W-1:0]       scan_idx,
  output logic [NUM_SENSORS-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   done,
  output logic                   alarm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                   state;
  logic [NUM_SENSORS-1:0]   mask_q;
  logic [CNT_W-1:0]         cnt;
  logic                     first_found;
  logic [IDX_W-1:0]         first_idx;
  logic                     next_found;
  logic [IDX_W-1:0]         next_idx;
  logic                     capture;

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_SENSORS'(1) << idx;
  endfunction

  // Lowest set bit of the incoming mask; scanning downward leaves the lowest one last.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (cfg_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest latched mask bit strictly above the current index; never wraps to 0.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(scan_idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  // sensor_en is one-hot on scan_idx in SAMPLE, so masking with it picks the sensor under test.
  assign capture = (state == S_SAMPLE) && (|(sensor_in & sensor_en));

  // Host handshake: result_valid rises on REPORT entry and holds result stable; the transfer
  // happens on the first rising edge with result_valid && result_ready, after which done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      cnt          <= '0;
      sensor_en    <= '0;
      busy         <= 1'b0;
      scan_idx     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        alarm <= 1'b1;
      end else if (clear_alarm) begin
        alarm <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= cfg_mask;
            result <= '0;
            busy   <= 1'b1;
            if (first_found) begin
              scan_idx  <= first_idx;
              sensor_en <= onehot(first_idx);
              state     <= S_ENABLE;
            end else begin
              result_valid <= 1'b1;
              state        <= S_REPORT;
            end
          end
        end

        S_ENABLE: begin
          cnt   <= CNT_W'(SETTLE_CYCLES);
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          result    <= result | (sensor_in & sensor_en);
          sensor_en <= '0;
          state     <= S_NEXT;
        end

        S_NEXT: begin
          if (next_found) begin
            scan_idx  <= next_idx;
            sensor_en <= onehot(next_idx);
            state     <= S_ENABLE;
          end else begin
            result_valid <= 1'b1;
            state        <= S_REPORT;
          end
        end

        S_REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            done         <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_en_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sensor_en));

  a_en_in_scan: assert property (@(posedge clk) disable iff (!rst_n)
    (|sensor_en) |-> (state inside {S_ENABLE, S_SETTLE, S_SAMPLE}));

  a_valid_in_report: assert property (@(posedge clk) disable iff (!rst_n)
    result_valid == (state == S_REPORT));

endmodule

// File: doc/sensor_scan_sched.md
Name: sensor_scan_sched

Overview:
- Sequencer for the sensor-group network in the vga_lcd control block.
- Powers up one sensor at a time through the bits selected in a configuration mask.
- For each sensor, it waits a programmable settle time, then samples the sensor's gated output.
- It collects the per-sensor results into a vector, hands it to the host over a valid/ready handshake, and keeps a sticky alarm.

Parameters:
- NUM_SENSORS, 10, number of sensor channels, index 0..NUM_SENSORS-1.
- IDX_W, 4, width of the scan index; must satisfy 2^IDX_W >= NUM_SENSORS.
- SETTLE_CYCLES, 4, cycles the enabled sensor settles before sampling; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  single block clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; accepted only in IDLE.
- cfg_mask  in  NUM_SENSORS  sensors to scan; latched when start is accepted.
- clear_alarm  in  1  synchronous clear of the sticky alarm.
- sensor_in  in  NUM_SENSORS  gated sensor outputs (isgN).
- sensor_en  out  NUM_SENSORS  one-hot enable of the sensor under test; all zero otherwise.
- busy  out  1  high in every state except IDLE.
- scan_idx  out  IDX_W  index of the sensor currently being scanned.
- result  out  NUM_SENSORS  sampled values; bits not in the mask read 0.
- result_valid  out  1  result is stable and offered to the host.
- result_ready  in  1  host accepts the result.
- done  out  1  one-cycle pulse after the result is accepted.
- alarm  out  1  sticky OR of all result bits since the last clear.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE.
  - sensor_en, scan_idx, result, result_valid, done, busy and alarm are all 0.
  - The latched mask and the settle counter are cleared.
- States and transitions:
  - IDLE: on start=1, latch cfg_mask and clear result. If the mask is 0, go to REPORT. Otherwise load scan_idx with the lowest set bit and go to ENABLE.
  - ENABLE (1 cycle): sensor_en[scan_idx]=1, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: sensor_en is held and the counter decrements. Go to SAMPLE when the counter reaches 1; SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): sensor_en is held; result[scan_idx] <= sensor_in[scan_idx]; go to NEXT.
  - NEXT (1 cycle): sensor_en=0. If a higher set mask bit exists, scan_idx moves to the lowest such bit and the state goes to ENABLE. Otherwise go to REPORT.
  - REPORT: result_valid=1. When result_valid and result_ready are both high, go to DONE.
  - DONE (1 cycle): done=1, result_valid=0, go to IDLE. result holds its value until the next accepted start.
- Timing:
  - Each sensor takes SETTLE_CYCLES+3 cycles.
  - sensor_en is high for SETTLE_CYCLES+2 consecutive cycles per sensor, with a gap of at least 1 cycle between sensors.
  - REPORT is entered k*(SETTLE_CYCLES+3) cycles after start is accepted, where k = popcount(mask). With mask=0, REPORT is entered on the next cycle.
- sensor_en is one-hot or zero at all times and is never high outside ENABLE, SETTLE and SAMPLE.
- start while busy is ignored and not queued. cfg_mask changes after acceptance have no effect.
- Alarm:
  - alarm is set in the cycle after a SAMPLE captures a 1.
  - If clear_alarm and a 1-capture occur in the same cycle, the set wins.
  - clear_alarm is legal in any state.
- If result_ready is already high on REPORT entry, the result is accepted in that first REPORT cycle.
- Index NUM_SENSORS-1 is the last candidate; the scan never wraps back to 0 within one scan.
- If rst_n asserts mid-scan, sensor_en drops immediately (asynchronous) and no partial result is reported.

Test Plan:
- Reset mid-SETTLE:
  - Stimulus: rst_n low for 1 cycle during SETTLE of sensor 2.
  - Required: sensor_en=0 immediately; busy=0, result=0 and alarm=0 from the next edge; the next start runs a full scan.
- Two-sensor scan (SETTLE_CYCLES=4):
  - Stimulus: mask=0x005, sensor_in=0x001, result_ready=1.
  - Required: sensor_en=0x001 for 6 cycles, 1 gap cycle, then 0x004 for 6 cycles; result_valid after 14 cycles; result=0x001, alarm=1, done pulse 1 cycle after REPORT.
- Empty mask:
  - Stimulus: mask=0.
  - Required: sensor_en is never asserted; result_valid on the cycle after start; result=0; alarm unchanged.
- Full mask with backpressure:
  - Stimulus: mask=0x3FF, sensor_in=0x000, result_ready held low for 5 REPORT cycles.
  - Required: scan_idx steps 0..9; REPORT entered 70 cycles after start; result_valid held for 6 cycles, 0x000 stable throughout; done only after ready goes high.
- start while busy:
  - Stimulus: second start with mask=0x200 during a 0x003 scan.
  - Required: ignored; result covers bits 0 and 1 only.
- Alarm clear/set collision:
  - Stimulus: clear_alarm=1 in the same cycle as a SAMPLE capturing 1 (alarm already 1).
  - Required: alarm stays 1. A later clear with no capture drops alarm to 0 on the next edge.
